pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It consumes the forwarding unit's hazard request (nop), the ID-stage redirect (taken branch/jal/jalr), and the instruction and data memory ready handshakes. It drives the enable and flush controls of the PC and all four pipeline registers. It also keeps a memory-wait watchdog and saturating performance counters.

---
 rtl/pipeline_stall_controller.sv | 136 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritises memory wait, hazard,
// redirect and fetch wait, and keeps a data-memory watchdog plus saturating counters.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hazard_nop,
    input  logic             redirect,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic [1:0]       ctrl_state,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HAZ  = 2'b01,
        ST_MEMW = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q;
    state_t            state_d;
    logic [WC_W-1:0]   wait_cnt;
    logic              is_err;
    logic              p2_memw;
    logic              p3_haz;
    logic              p4_redir;
    logic              p5_fetchw;
    logic              wd_expire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // One-hot priority classification of the current cycle
    assign is_err    = (state_q == ST_ERR);
    assign p2_memw   = !is_err && dmem_req && !dmem_ready;
    assign p3_haz    = !is_err && !p2_memw && hazard_nop;
    assign p4_redir  = !is_err && !p2_memw && !p3_haz && redirect;
    assign p5_fetchw = !is_err && !p2_memw && !p3_haz && !p4_redir && !imem_ready;
    assign wd_expire = p2_memw && (wait_cnt == WC_W'(MEM_TIMEOUT - 1));

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (is_err) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (p2_memw) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (p3_haz) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (p4_redir) begin
            if_id_flush = 1'b1;
        end else if (p5_fetchw) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (is_err || wd_expire) begin
            state_d = ST_ERR;
        end else if (p2_memw) begin
            state_d = ST_MEMW;
        end else if (p3_haz) begin
            state_d = ST_HAZ;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            wait_cnt     <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state_q <= state_d;
            if (p2_memw) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (wd_expire) begin
                mem_error <= 1'b1;
            end
            if (!pc_en) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (p4_redir) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

    assign ctrl_state = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with a cycle-level reference model
// and literal spot checks on the key scenarios.
module tb_pipeline_stall_controller;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          hazard_nop = 1'b0;
    logic          redirect = 1'b0;
    logic          imem_ready = 1'b1;
    logic          dmem_req = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic [1:0]    ctrl_state;
    logic          mem_error;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;

    pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .hazard_nop(hazard_nop), .redirect(redirect),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_flush(mem_wb_flush), .ctrl_state(ctrl_state), .mem_error(mem_error),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Reference model: registered view of the controller after the last edge
    bit m_valid = 0;
    bit m_err;
    int m_state, m_wait, m_stall, m_flush;

    always @(negedge clock) begin
        int e_pc, e_ifen, e_iffl, e_idxen, e_idxfl, e_exen, e_wbfl;
        bit memw, haz, redir;
        e_pc = 1; e_ifen = 1; e_iffl = 0; e_idxen = 1; e_idxfl = 0; e_exen = 1; e_wbfl = 0;
        memw = 0; haz = 0; redir = 0;
        if (reset) begin
            e_pc = 0; e_ifen = 0; e_idxen = 0; e_exen = 0; e_iffl = 1; e_idxfl = 1; e_wbfl = 1;
        end else if (m_err) begin
            e_pc = 0; e_ifen = 0; e_idxen = 0; e_exen = 0;
        end else if (dmem_req && !dmem_ready) begin
            memw = 1;
            e_pc = 0; e_ifen = 0; e_idxen = 0; e_exen = 0; e_wbfl = 1;
        end else if (hazard_nop) begin
            haz = 1;
            e_pc = 0; e_ifen = 0; e_idxfl = 1;
        end else if (redirect) begin
            redir = 1;
            e_iffl = 1;
        end else if (!imem_ready) begin
            e_pc = 0; e_iffl = 1;
        end
        chk("m_pc_en", int'(pc_en), e_pc);
        chk("m_if_id_en", int'(if_id_en), e_ifen);
        chk("m_if_id_flush", int'(if_id_flush), e_iffl);
        chk("m_id_ex_en", int'(id_ex_en), e_idxen);
        chk("m_id_ex_flush", int'(id_ex_flush), e_idxfl);
        chk("m_ex_mem_en", int'(ex_mem_en), e_exen);
        chk("m_mem_wb_flush", int'(mem_wb_flush), e_wbfl);
        if (m_valid) begin
            chk("m_ctrl_state", int'(ctrl_state), m_state);
            chk("m_mem_error", int'(mem_error), int'(m_err));
            chk("m_stall_cycles", int'(stall_cycles), m_stall);
            chk("m_flush_count", int'(flush_count), m_flush);
        end
        // advance model to the value expected after the coming rising edge
        if (reset) begin
            m_valid = 1; m_err = 0; m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else if (m_valid) begin
            if (e_pc == 0 && m_stall < CMAX) m_stall++;
            if (redir && m_flush < CMAX) m_flush++;
            if (m_err) begin
                m_state = 3;
                m_wait = 0;
            end else if (memw) begin
                if (m_wait == TO - 1) begin
                    m_err = 1;
                    m_state = 3;
                end else begin
                    m_state = 2;
                end
                m_wait++;
            end else begin
                m_state = haz ? 1 : 0;
                m_wait = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit h, input bit r, input bit i, input bit q, input bit d);
        hazard_nop = h; redirect = r; imem_ready = i; dmem_req = q; dmem_ready = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 1, 0, 0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_if_id_flush", int'(if_id_flush), 1);
        chk("rst_mem_wb_flush", int'(mem_wb_flush), 1);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("idle_pc_en", int'(pc_en), 1);
        chk("idle_id_ex_flush", int'(id_ex_flush), 0);
        chk("idle_state", int'(ctrl_state), 0);
        chk("idle_stall", int'(stall_cycles), 0);
        chk("idle_flush", int'(flush_count), 0);

        // single-cycle hazard
        drive(1, 0, 1, 0, 0);
        #1;
        chk("haz_pc_en", int'(pc_en), 0);
        chk("haz_if_id_en", int'(if_id_en), 0);
        chk("haz_id_ex_flush", int'(id_ex_flush), 1);
        chk("haz_ex_mem_en", int'(ex_mem_en), 1);
        step();
        drive(0, 0, 1, 0, 0);
        chk("haz_state", int'(ctrl_state), 1);
        chk("haz_stall", int'(stall_cycles), 1);
        step();
        chk("haz_back_run", int'(ctrl_state), 0);

        // memory wait overrides hazard and redirect
        do_reset();
        drive(1, 1, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("memw_pc_en", int'(pc_en), 0);
            chk("memw_ex_mem_en", int'(ex_mem_en), 0);
            chk("memw_mem_wb_flush", int'(mem_wb_flush), 1);
            chk("memw_if_id_flush", int'(if_id_flush), 0);
            step();
        end
        drive(0, 0, 1, 0, 0);
        chk("memw_stall", int'(stall_cycles), 3);
        chk("memw_flush", int'(flush_count), 0);
        chk("memw_state", int'(ctrl_state), 2);
        step();

        // watchdog timeout
        do_reset();
        drive(0, 0, 1, 1, 0);
        repeat (3) step();
        chk("wd_err_early", int'(mem_error), 0);
        chk("wd_state_early", int'(ctrl_state), 2);
        step();
        chk("wd_err", int'(mem_error), 1);
        chk("wd_state", int'(ctrl_state), 3);
        drive(1, 1, 0, 0, 0);
        #1;
        chk("err_pc_en", int'(pc_en), 0);
        chk("err_if_id_en", int'(if_id_en), 0);
        chk("err_if_id_flush", int'(if_id_flush), 0);
        chk("err_id_ex_flush", int'(id_ex_flush), 0);
        chk("err_mem_wb_flush", int'(mem_wb_flush), 0);
        step();
        step();
        chk("err_sticky", int'(ctrl_state), 3);
        chk("err_stall", int'(stall_cycles), 6);
        chk("err_flush", int'(flush_count), 0);
        do_reset();
        chk("err_cleared", int'(mem_error), 0);
        chk("err_state_run", int'(ctrl_state), 0);

        // redirect ignores fetch wait, loses to hazard
        drive(0, 1, 0, 0, 0);
        #1;
        chk("redir_pc_en", int'(pc_en), 1);
        chk("redir_if_id_flush", int'(if_id_flush), 1);
        step();
        chk("redir_flush", int'(flush_count), 1);
        drive(1, 1, 1, 0, 0);
        #1;
        chk("redir_haz_pc_en", int'(pc_en), 0);
        step();
        chk("redir_haz_flush", int'(flush_count), 1);
        chk("redir_haz_state", int'(ctrl_state), 1);

        // flush counter saturation
        do_reset();
        drive(0, 1, 1, 0, 0);
        repeat (15) step();
        chk("flush_15", int'(flush_count), 15);
        repeat (2) step();
        chk("flush_sat", int'(flush_count), 15);

        // two-cycle hazard, then stall saturation via fetch wait
        drive(1, 0, 1, 0, 0);
        step();
        chk("haz2_state1", int'(ctrl_state), 1);
        step();
        chk("haz2_state2", int'(ctrl_state), 1);
        chk("haz2_stall", int'(stall_cycles), 2);
        drive(0, 0, 0, 0, 0);
        repeat (18) step();
        chk("stall_sat", int'(stall_cycles), 15);

        // reset asserted mid-stall
        do_reset();
        drive(0, 0, 1, 1, 0);
        step();
        reset = 1'b1;
        #1;
        chk("midrst_pc_en", int'(pc_en), 0);
        chk("midrst_if_id_flush", int'(if_id_flush), 1);
        chk("midrst_id_ex_flush", int'(id_ex_flush), 1);
        step();
        reset = 1'b0;

        // sweep all input combinations under the model
        for (int v = 0; v < 32; v++) begin
            drive(v[4], v[3], v[2], v[1], v[0]);
            step();
        end
        drive(0, 0, 1, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
